// File: rtl/ipm_mcu_master_pkg.sv
// Shared types and constants for the IPM MCU-side byte bus master.
// Holds the host opcodes, the MCU register map and the sequencer state encoding.
package ipm_mcu_master_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ  = 2'b01,
      OP_START = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   localparam logic [3:0] ADDR_DATA0 = 4'd0;
   localparam logic [3:0] ADDR_DATA1 = 4'd1;
   localparam logic [3:0] ADDR_DATA2 = 4'd2;
   localparam logic [3:0] ADDR_DATA3 = 4'd3;
   localparam logic [3:0] ADDR_CONF  = 4'd4;
   localparam logic [3:0] ADDR_CTRL  = 4'd5;

   localparam logic [7:0] START_VAL  = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } state_e;

endpackage

// File: rtl/ipm_mcu_sync_edge.sv
// Two-flop synchronizer for an asynchronous input with a one-cycle rising-edge pulse.
module ipm_mcu_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;

   always_comb begin
      s1_d   = async_i;
      s2_d   = s1_q;
      prev_d = s2_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
      end
   end

   assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/ipm_mcu_master.sv
// Host-command to MCU byte-bus master: word writes/reads through a conf+data byte
// sequence with programmable setup/strobe timing, plus a sticky interrupt flag.
module ipm_mcu_master
   import ipm_mcu_master_pkg::*;
#(
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_conf,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        irq,
   input  logic        irq_clr,
   output logic [3:0]  addressMCU,
   output logic        rdMCU,
   output logic        wrMCU,
   output logic [7:0]  dataMCU_o,
   output logic        dataMCU_oe,
   input  logic [7:0]  dataMCU_i,
   output logic        rstMCU,
   input  logic        intMCU
);

   state_e      state_q, state_d;
   op_e         op_q, op_d;
   logic [2:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [4:0]  conf_q, conf_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic [31:0] rdata_q, rdata_d;
   logic        irq_q, irq_d;
   logic        rst_mcu_q, rst_mcu_d;

   logic [3:0]  acc_addr;
   logic [7:0]  acc_data;
   logic        acc_wr;
   logic        last_byte;
   logic        busy;
   logic        int_rise;

   ipm_mcu_sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (intMCU),
      .rise_o  (int_rise)
   );

   // Index 0 is the conf write; 1..4 are data bytes LSB-first. Start is a lone CTRL write.
   always_comb begin
      acc_addr = ADDR_CONF;
      acc_data = {3'b000, conf_q};
      acc_wr   = 1'b1;
      if (op_q == OP_START) begin
         acc_addr = ADDR_CTRL;
         acc_data = START_VAL;
      end else begin
         case (idx_q)
            3'd1: begin acc_addr = ADDR_DATA0; acc_data = wdata_q[7:0];   acc_wr = (op_q != OP_READ); end
            3'd2: begin acc_addr = ADDR_DATA1; acc_data = wdata_q[15:8];  acc_wr = (op_q != OP_READ); end
            3'd3: begin acc_addr = ADDR_DATA2; acc_data = wdata_q[23:16]; acc_wr = (op_q != OP_READ); end
            3'd4: begin acc_addr = ADDR_DATA3; acc_data = wdata_q[31:24]; acc_wr = (op_q != OP_READ); end
            default: ;
         endcase
      end
   end

   assign last_byte = (op_q == OP_START) || (idx_q == 3'd4);
   assign busy      = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      conf_d    = conf_q;
      wdata_d   = wdata_q;
      rbuf_d    = rbuf_q;
      rdata_d   = rdata_q;
      rst_mcu_d = 1'b1;
      irq_d     = int_rise ? 1'b1 : (irq_clr ? 1'b0 : irq_q);

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_d    = op_e'(cmd_op);
               conf_d  = cmd_conf;
               wdata_d = cmd_wdata;
               idx_d   = 3'd0;
               cnt_d   = 4'd0;
               state_d = (op_e'(cmd_op) == OP_RSVD) ? ST_DONE : ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(SETUP_CYCLES - 1)) begin
               cnt_d   = 4'd0;
               state_d = ST_STROBE;
            end
         end
         ST_STROBE: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(STROBE_CYCLES - 1)) begin
               cnt_d   = 4'd0;
               state_d = ST_HOLD;
               if (!acc_wr) begin
                  case (idx_q)
                     3'd1:    rbuf_d[7:0]   = dataMCU_i;
                     3'd2:    rbuf_d[15:8]  = dataMCU_i;
                     3'd3:    rbuf_d[23:16] = dataMCU_i;
                     3'd4:    rbuf_d[31:24] = dataMCU_i;
                     default: ;
                  endcase
               end
            end
         end
         ST_HOLD: begin
            if (last_byte) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = ST_SETUP;
            end
         end
         ST_DONE: begin
            if (op_q == OP_READ) rdata_d = rbuf_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_WRITE;
         idx_q     <= 3'd0;
         cnt_q     <= 4'd0;
         conf_q    <= 5'd0;
         wdata_q   <= 32'd0;
         rbuf_q    <= 32'd0;
         rdata_q   <= 32'd0;
         irq_q     <= 1'b0;
         rst_mcu_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         conf_q    <= conf_d;
         wdata_q   <= wdata_d;
         rbuf_q    <= rbuf_d;
         rdata_q   <= rdata_d;
         irq_q     <= irq_d;
         rst_mcu_q <= rst_mcu_d;
      end
   end

   // rst_mcu_q doubles as the "out of reset" qualifier so ready stays low until the first clock.
   assign cmd_ready  = (state_q == ST_IDLE) && rst_mcu_q;
   assign rsp_valid  = (state_q == ST_DONE);
   assign rsp_err    = (state_q == ST_DONE) && (op_q == OP_RSVD);
   assign rsp_rdata  = rdata_q;
   assign irq        = irq_q;
   assign rstMCU     = rst_mcu_q;
   assign addressMCU = busy ? acc_addr : 4'd0;
   assign dataMCU_oe = busy && acc_wr;
   assign dataMCU_o  = (busy && acc_wr) ? acc_data : 8'd0;
   assign wrMCU      = (state_q == ST_STROBE) && acc_wr;
   assign rdMCU      = (state_q == ST_STROBE) && !acc_wr;

endmodule
